// File: rtl/impulse_scheduler.sv
// Impulse sequence scheduler: timed start, periodic TX/BLANK gating and stepped frequency word.
// Define IMPULSE_SCHED_ABORT_EN to let SPI_WR outside IDLE abort and re-arm the sequence.
module impulse_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        SPI_WR,
  input  logic [63:0] SYS_TIME,
  input  logic [63:0] TIME_START,
  input  logic [15:0] N_impulse,
  input  logic [7:0]  TYPE_impulse,
  input  logic [31:0] Interval_Ti,
  input  logic [31:0] Interval_Tp,
  input  logic [31:0] Tblank1,
  input  logic [31:0] Tblank2,
  input  logic [47:0] FREQ,
  input  logic [47:0] FREQ_STEP,
  input  logic [31:0] FREQ_RATE,
  output logic        TX_EN,
  output logic        BLANK,
  output logic [47:0] FREQ_OUT,
  output logic        FREQ_UPD,
  output logic [7:0]  TYPE_OUT,
  output logic [15:0] IMP_CNT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR_LATE,
  output logic        ERR_BUSY
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StFin   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rate_cnt_q, rate_cnt_d;
  logic [15:0] imp_q, imp_d;
  logic [47:0] freq_q, freq_d;
  logic        upd_q, upd_d;
  logic        late_q, late_d;
  logic        busy_err_q, busy_err_d;

  logic [63:0] ts_q;
  logic [15:0] n_q;
  logic [7:0]  type_q;
  logic [31:0] ti_q, tp_q, tb1_q, tb2_q, rate_q;
  logic [47:0] step_q;

  logic        load;
  logic [31:0] tp_eff, tb2_eff, rate_nxt;
  logic        period_end;

  always_comb begin
    tp_eff     = (tp_q == 32'd0) ? 32'd1 : tp_q;
    tb2_eff    = (tb2_q > tp_eff) ? tp_eff : tb2_q;
    period_end = (pc_q == tp_eff - 32'd1);
    rate_nxt   = rate_cnt_q + 32'd1;

    load       = 1'b0;
    state_d    = state_q;
    pc_d       = pc_q;
    rate_cnt_d = rate_cnt_q;
    imp_d      = imp_q;
    freq_d     = freq_q;
    upd_d      = 1'b0;
    late_d     = 1'b0;
    busy_err_d = 1'b0;

    if (clk_en) begin
      if (SPI_WR) begin
        if (state_q == StIdle) begin
          load = 1'b1;
        end else begin
`ifdef IMPULSE_SCHED_ABORT_EN
          load = 1'b1;
`else
          busy_err_d = 1'b1;
`endif
        end
      end

      if (load) begin
        state_d    = (N_impulse == 16'd0) ? StFin : StArmed;
        late_d     = (N_impulse != 16'd0) && (SYS_TIME > TIME_START);
        freq_d     = FREQ;
        imp_d      = 16'd0;
        pc_d       = 32'd0;
        rate_cnt_d = 32'd0;
      end else begin
        case (state_q)
          StArmed: begin
            if (SYS_TIME >= ts_q) begin
              state_d    = StRun;
              pc_d       = 32'd0;
              rate_cnt_d = 32'd0;
              imp_d      = imp_q + 16'd1;
            end
          end
          StRun: begin
            if (!period_end) begin
              pc_d = pc_q + 32'd1;
            end else if (imp_q == n_q) begin
              state_d = StFin;
            end else begin
              pc_d  = 32'd0;
              imp_d = imp_q + 16'd1;
              // rate_cnt counts impulses since the last step, so no divider is needed
              if (rate_q != 32'd0) begin
                if (rate_nxt == rate_q) begin
                  rate_cnt_d = 32'd0;
                  freq_d     = freq_q + step_q;
                  upd_d      = 1'b1;
                end else begin
                  rate_cnt_d = rate_nxt;
                end
              end
            end
          end
          StFin:   state_d = StIdle;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      rate_cnt_q <= '0;
      imp_q      <= '0;
      freq_q     <= '0;
      upd_q      <= 1'b0;
      late_q     <= 1'b0;
      busy_err_q <= 1'b0;
      ts_q       <= '0;
      n_q        <= '0;
      type_q     <= '0;
      ti_q       <= '0;
      tp_q       <= '0;
      tb1_q      <= '0;
      tb2_q      <= '0;
      rate_q     <= '0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rate_cnt_q <= rate_cnt_d;
      imp_q      <= imp_d;
      freq_q     <= freq_d;
      upd_q      <= upd_d;
      late_q     <= late_d;
      busy_err_q <= busy_err_d;
      if (load) begin
        ts_q   <= TIME_START;
        n_q    <= N_impulse;
        type_q <= TYPE_impulse;
        ti_q   <= Interval_Ti;
        tp_q   <= Interval_Tp;
        tb1_q  <= Tblank1;
        tb2_q  <= Tblank2;
        rate_q <= FREQ_RATE;
        step_q <= FREQ_STEP;
      end
    end
  end

  // pc never reaches tp_eff, so pc < Ti already implies pc < min(Ti, tp_eff)
  assign TX_EN    = (state_q == StRun) && (pc_q < ti_q);
  assign BLANK    = (state_q == StRun) && ((pc_q < tb1_q) || (pc_q >= tp_eff - tb2_eff));
  assign FREQ_OUT = freq_q;
  assign TYPE_OUT = type_q;
  assign IMP_CNT  = imp_q;
  assign BUSY     = (state_q != StIdle);
  assign DONE     = (state_q == StFin) && clk_en && !load;
  assign FREQ_UPD = upd_q & clk_en;
  assign ERR_LATE = late_q & clk_en;
  assign ERR_BUSY = busy_err_q & clk_en;

endmodule

// File: tb/tb_impulse_scheduler.sv
// Randomized and directed bench for impulse_scheduler against an arithmetic reference model.
// Honours IMPULSE_SCHED_ABORT_EN the same way the design does.
module tb_impulse_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clk_en, spi_wr;
  logic [63:0] sys_time, time_start;
  logic [15:0] n_imp;
  logic [7:0]  typ;
  logic [31:0] ti, tp, tb1, tb2, rate;
  logic [47:0] freq, fstep;
  logic        tx_en, blank, freq_upd, busy, done, err_late, err_busy;
  logic [47:0] freq_out;
  logic [7:0]  type_out;
  logic [15:0] imp_cnt;

  impulse_scheduler dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .SPI_WR(spi_wr), .SYS_TIME(sys_time),
    .TIME_START(time_start), .N_impulse(n_imp), .TYPE_impulse(typ), .Interval_Ti(ti),
    .Interval_Tp(tp), .Tblank1(tb1), .Tblank2(tb2), .FREQ(freq), .FREQ_STEP(fstep),
    .FREQ_RATE(rate), .TX_EN(tx_en), .BLANK(blank), .FREQ_OUT(freq_out),
    .FREQ_UPD(freq_upd), .TYPE_OUT(type_out), .IMP_CNT(imp_cnt), .BUSY(busy),
    .DONE(done), .ERR_LATE(err_late), .ERR_BUSY(err_busy)
  );

  int n_vec = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @t=%0d: got %0h expected %0h", tag, sys_time, got, exp);
    end
  endtask

  // Reference model: sequence described by elapsed run ticks; pc and impulse index derived
  localparam int MIdle = 0, MArmed = 1, MRun = 2, MFin = 3;
  int                m_mode;
  longint unsigned   m_ticks;
  logic [63:0]       p_ts;
  longint unsigned   p_n, p_ti, p_tp, p_tb1, p_tb2, p_rate;
  logic [47:0]       p_f0, p_step, m_freq;
  logic [7:0]        m_type;
  longint unsigned   m_imp;
  bit                m_upd, m_late, m_berr;

  function automatic longint unsigned tpe();
    return (p_tp == 0) ? 64'd1 : p_tp;
  endfunction

  task automatic model_load();
    p_ts = time_start; p_n = 64'(n_imp); p_ti = 64'(ti); p_tp = 64'(tp);
    p_tb1 = 64'(tb1); p_tb2 = 64'(tb2); p_rate = 64'(rate);
    p_f0 = freq; p_step = fstep; m_freq = freq; m_type = typ; m_imp = 0;
    m_late = (n_imp != 0) && (sys_time > time_start);
    m_mode = (n_imp == 0) ? MFin : MArmed;
  endtask

  task automatic model_run_update();
    longint unsigned k, steps, f;
    k = m_ticks / tpe();
    steps = (p_rate == 0) ? 64'd0 : k / p_rate;
    f = 64'(p_f0) + 64'(p_step) * steps;
    m_imp = k + 1;
    m_freq = f[47:0];
  endtask

  task automatic model_step();
    bit ld;
    ld = 0;
    m_upd = 0; m_late = 0; m_berr = 0;
    if (rst) begin
      m_mode = MIdle; m_freq = '0; m_type = '0; m_imp = 0;
    end else if (clk_en) begin
      if (spi_wr) begin
        if (m_mode == MIdle) ld = 1;
        else begin
`ifdef IMPULSE_SCHED_ABORT_EN
          ld = 1;
`else
          m_berr = 1;
`endif
        end
      end
      if (ld) model_load();
      else if (m_mode == MArmed) begin
        if (sys_time >= p_ts) begin
          m_mode = MRun; m_ticks = 0; model_run_update();
        end
      end else if (m_mode == MRun) begin
        m_ticks++;
        if (m_ticks == p_n * tpe()) m_mode = MFin;
        else begin
          model_run_update();
          if (m_ticks % tpe() == 0 && p_rate != 0 && (m_ticks / tpe()) % p_rate == 0) m_upd = 1;
        end
      end else if (m_mode == MFin) m_mode = MIdle;
    end
  endtask

  task automatic compare_all();
    longint unsigned pc, t2;
    bit run, e_tx, e_blank;
    run = (m_mode == MRun);
    pc = m_ticks % tpe();
    t2 = (p_tb2 < tpe()) ? p_tb2 : tpe();
    e_tx = run && (pc < p_ti);
    e_blank = run && ((pc < p_tb1) || (pc + t2 >= tpe()));
    check_eq("tx_en", 64'(tx_en), 64'(e_tx));
    check_eq("blank", 64'(blank), 64'(e_blank));
    check_eq("busy", 64'(busy), 64'(m_mode != MIdle));
    check_eq("done", 64'(done), 64'(m_mode == MFin && clk_en));
    check_eq("freq_out", 64'(freq_out), 64'(m_freq));
    check_eq("freq_upd", 64'(freq_upd), 64'(m_upd && clk_en));
    check_eq("type_out", 64'(type_out), 64'(m_type));
    check_eq("imp_cnt", 64'(imp_cnt), m_imp);
    check_eq("err_late", 64'(err_late), 64'(m_late && clk_en));
    check_eq("err_busy", 64'(err_busy), 64'(m_berr && clk_en));
  endtask

  // Observed-output statistics for the directed scenarios
  int tx_cnt, blank_cnt, upd_cnt, done_cnt, berr_cnt, tx_rises;
  longint first_rise, last_rise;
  logic tx_prev;

  task automatic clr_stats();
    tx_cnt = 0; blank_cnt = 0; upd_cnt = 0; done_cnt = 0; berr_cnt = 0; tx_rises = 0;
    first_rise = -1; last_rise = -1; tx_prev = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    sys_time = sys_time + 64'd1;
    spi_wr = 1'b0;
    compare_all();
    if (tx_en && !tx_prev) begin
      if (first_rise < 0) first_rise = longint'(sys_time);
      last_rise = longint'(sys_time);
      tx_rises++;
    end
    tx_prev = tx_en;
    if (tx_en) tx_cnt++;
    if (blank) blank_cnt++;
    if (freq_upd) upd_cnt++;
    if (done) done_cnt++;
    if (err_busy) berr_cnt++;
  endtask

  task automatic load_seq(input longint unsigned ts, input int n, input int t_i, input int t_p,
                          input int b1, input int b2, input logic [47:0] f,
                          input logic [47:0] st, input int r);
    time_start = 64'(ts); n_imp = 16'(n); ti = 32'(t_i); tp = 32'(t_p);
    tb1 = 32'(b1); tb2 = 32'(b2); freq = f; fstep = st; rate = 32'(r);
    typ = 8'($urandom_range(0, 255));
    spi_wr = 1'b1;
    tick();
  endtask

  task automatic run_until_idle(input int budget);
    int g;
    g = 0;
    while (m_mode != MIdle && g < budget) begin
      tick();
      g++;
    end
    if (m_mode != MIdle) check_eq("idle_timeout", 64'(g), 64'(budget + 1));
  endtask

  task automatic wait_rises(input int n);
    int g;
    g = 0;
    while (tx_rises < n && g < 200) begin
      tick();
      g++;
    end
    if (tx_rises < n) check_eq("rise_timeout", 64'(tx_rises), 64'(n));
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; spi_wr = 1'b0; sys_time = '0; time_start = '0;
    n_imp = '0; typ = '0; ti = '0; tp = '0; tb1 = '0; tb2 = '0; rate = '0;
    freq = '0; fstep = '0;
    m_mode = MIdle; m_ticks = 0; p_ts = '0; p_n = 0; p_ti = 0; p_tp = 0; p_tb1 = 0;
    p_tb2 = 0; p_rate = 0; p_f0 = '0; p_step = '0; m_freq = '0; m_type = '0; m_imp = 0;
    m_upd = 0; m_late = 0; m_berr = 0;
    clr_stats();
    repeat (3) tick();
    rst = 1'b0;

    // Basic timing: start at 100, strobe at 20
    while (sys_time < 64'd20) tick();
    clr_stats();
    load_seq(100, 2, 3, 10, 0, 0, 48'd7, 48'd0, 0);
    run_until_idle(200);
    check_eq("basic_first_rise", 64'(first_rise), 64'd101);
    check_eq("basic_last_rise", 64'(last_rise), 64'd111);
    check_eq("basic_tx_cnt", 64'(tx_cnt), 64'd6);
    check_eq("basic_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("basic_imp_cnt", 64'(imp_cnt), 64'd2);

    // Blanking windows
    clr_stats();
    load_seq(sys_time, 1, 0, 10, 2, 3, 48'd0, 48'd0, 0);
    run_until_idle(100);
    check_eq("blank_cnt", 64'(blank_cnt), 64'd5);
    clr_stats();
    load_seq(sys_time, 1, 0, 10, 0, 20, 48'd0, 48'd0, 0);
    run_until_idle(100);
    check_eq("blank_full", 64'(blank_cnt), 64'd10);

    // Frequency stepping and 48-bit wrap
    clr_stats();
    load_seq(sys_time + 2, 5, 1, 3, 0, 0, 48'd1, 48'd2, 2);
    run_until_idle(100);
    check_eq("step_upd_cnt", 64'(upd_cnt), 64'd2);
    check_eq("step_final", 64'(freq_out), 64'd5);
    clr_stats();
    load_seq(sys_time + 2, 2, 1, 3, 0, 0, 48'hFFFF_FFFF_FFFF, 48'd1, 1);
    run_until_idle(100);
    check_eq("wrap_final", 64'(freq_out), 64'd0);

    // Late start, then empty sequence
    while (sys_time < 64'd50) tick();
    load_seq(5, 2, 1, 2, 0, 0, 48'd0, 48'd0, 0);
    check_eq("late_pulse", 64'(err_late), 64'd1);
    run_until_idle(100);
    clr_stats();
    load_seq(sys_time + 3, 0, 5, 5, 0, 0, 48'd0, 48'd0, 0);
    run_until_idle(100);
    check_eq("n0_done", 64'(done_cnt), 64'd1);
    check_eq("n0_tx", 64'(tx_cnt), 64'd0);

    // SPI_WR during RUN
    clr_stats();
    load_seq(sys_time + 2, 3, 3, 10, 0, 0, 48'd0, 48'd0, 0);
    wait_rises(2);
    repeat (2) tick();
    load_seq(sys_time + 3, 2, 2, 6, 0, 0, 48'd9, 48'd0, 0);
    run_until_idle(200);
`ifdef IMPULSE_SCHED_ABORT_EN
    check_eq("abort_tx_cnt", 64'(tx_cnt), 64'd10);
    check_eq("abort_berr", 64'(berr_cnt), 64'd0);
`else
    check_eq("busy_tx_cnt", 64'(tx_cnt), 64'd9);
    check_eq("busy_berr", 64'(berr_cnt), 64'd1);
`endif
    check_eq("wr_run_done", 64'(done_cnt), 64'd1);

    // Reset at pc=4 of impulse 1
    clr_stats();
    load_seq(sys_time + 2, 3, 3, 10, 1, 1, 48'd33, 48'd1, 1);
    wait_rises(2);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_imp", 64'(imp_cnt), 64'd0);
    check_eq("rst_freq", 64'(freq_out), 64'd0);
    check_eq("rst_tx", 64'(tx_en), 64'd0);

    // clk_en stall mid-impulse stretches the period by 5 cycles
    clr_stats();
    load_seq(sys_time + 2, 2, 3, 10, 0, 0, 48'd0, 48'd0, 0);
    wait_rises(1);
    repeat (4) tick();
    clk_en = 1'b0;
    repeat (5) tick();
    clk_en = 1'b1;
    run_until_idle(100);
    check_eq("stall_rise_gap", 64'(last_rise - first_rise), 64'd15);

    // Randomized sequences with clk_en gaps, stray strobes and occasional reset
    for (int it = 0; it < 30; it++) begin
      longint unsigned ts;
      int g;
      ts = sys_time + 64'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) ts = sys_time - 64'd3;
      clk_en = 1'b1;
      load_seq(ts, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 8)), int'($urandom_range(0, 9)),
               int'($urandom_range(0, 10)), 48'({$urandom(), $urandom()}),
               48'({$urandom(), $urandom()}), int'($urandom_range(0, 3)));
      g = 0;
      while (m_mode != MIdle && g < 400) begin
        clk_en = ($urandom_range(0, 9) != 0);
        if (g < 100 && $urandom_range(0, 29) == 0) spi_wr = 1'b1;
        rst = ($urandom_range(0, 149) == 0);
        tick();
        rst = 1'b0;
        g++;
      end
      clk_en = 1'b1;
      if (m_mode != MIdle) check_eq("rand_timeout", 64'(g), 64'd401);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/impulse_scheduler.md
IMPULSE_SCHEDULER -- requirements
Module: impulse_scheduler

Interface
REQ-001 clk  in  1  system clock, 48 MHz domain; all logic on rising edge.
REQ-002 rst  in  1  synchronous reset, active-high.
REQ-003 clk_en  in  1  clock enable; when low, all state, counters and outputs hold.
REQ-004 SPI_WR  in  1  one-cycle strobe: new parameter frame valid on the parameter inputs.
REQ-005 SYS_TIME  in  64  free-running system time, in clk ticks.
REQ-006 TIME_START  in  64  sequence start time, SYS_TIME units.
REQ-007 N_impulse  in  16  number of impulses in the sequence.
REQ-008 TYPE_impulse  in  8  impulse type, latched and passed to TYPE_OUT.
REQ-009 Interval_Ti  in  32  pulse width, in cycles.
REQ-010 Interval_Tp  in  32  repetition period, in cycles.
REQ-011 Tblank1, Tblank2  in  32 each  leading and trailing blanking lengths, in cycles.
REQ-012 FREQ, FREQ_STEP  in  48 each  start frequency word and per-step increment.
REQ-013 FREQ_RATE  in  32  impulses per frequency step; 0 disables stepping.
REQ-014 TX_EN  out  1  transmit gate.
REQ-015 BLANK  out  1  receiver blanking gate.
REQ-016 FREQ_OUT  out  48  current frequency word. FREQ_UPD  out  1  one-cycle pulse when FREQ_OUT changes.
REQ-017 TYPE_OUT  out  8  latched type. IMP_CNT  out  16  impulses started.
REQ-018 BUSY  out  1  high when not in IDLE. DONE  out  1  one-cycle end-of-sequence pulse.
REQ-019 ERR_LATE  out  1  one-cycle pulse on a late start. ERR_BUSY  out  1  one-cycle pulse when SPI_WR is rejected.

Function
REQ-020 The FSM SHALL have states IDLE, ARMED, RUN and FIN.
REQ-021 IDLE + SPI_WR: latch all parameter inputs into shadow registers, load FREQ_OUT=FREQ, clear IMP_CNT, go to ARMED; a latched N_impulse=0 goes to FIN instead.
REQ-022 ARMED: when SYS_TIME >= latched TIME_START (unsigned 64-bit compare), go to RUN with period counter pc=0; TX_EN rises one cycle after the compare is first true.
REQ-023 When SYS_TIME > TIME_START in the cycle of the ARMED entry, ERR_LATE SHALL pulse and RUN SHALL start normally.
REQ-024 RUN: pc counts 0..Tp_eff-1, where Tp_eff=max(Interval_Tp,1); IMP_CNT increments at each pc=0.
REQ-025 TX_EN = RUN && pc < min(Ti,Tp_eff); Ti=0 keeps TX_EN low throughout.
REQ-026 BLANK = RUN && (pc < Tblank1 || pc >= Tp_eff - min(Tblank2,Tp_eff)).
REQ-027 FREQ stepping: with FREQ_RATE=R≠0, at pc=0 of impulse k (k≥1, 0-based) where k mod R = 0, FREQ_OUT += FREQ_STEP modulo 2^48 and FREQ_UPD pulses in the same cycle.
REQ-028 After pc=Tp_eff-1 of impulse N_impulse-1, go to FIN; FIN pulses DONE for one cycle and returns to IDLE.
REQ-029 SPI_WR outside IDLE SHALL follow REQ-041.
REQ-030 FREQ_OUT, TYPE_OUT and IMP_CNT SHALL hold their last values in IDLE.
REQ-031 clk_en=0 freezes the FSM, pc and the SYS_TIME compare result; strobes (FREQ_UPD, DONE, ERR_*) are not asserted while clk_en=0.

Reset
REQ-032 rst SHALL force IDLE and zero every output and shadow register within one clock, including mid-sequence; any pending start is lost.
REQ-033 rst SHALL take priority over SPI_WR and clk_en.

Configuration
REQ-040 The macro IMPULSE_SCHED_ABORT_EN SHALL select the handling of SPI_WR outside IDLE.
REQ-041 With the macro defined: SPI_WR in ARMED/RUN/FIN drops TX_EN and BLANK next cycle, re-latches the parameters and re-enters ARMED, with no DONE pulse. Without the macro: SPI_WR is ignored, ERR_BUSY pulses and the sequence continues unchanged.

Verification
REQ-050 Ti=3, Tp=10, N=2, TIME_START=100, SPI_WR at SYS_TIME=20 -> TX_EN high at SYS_TIME 101-103 and 111-113; DONE one cycle after the last pc=9; IMP_CNT=2.
REQ-051 Tblank1=2, Tblank2=3, Tp=10 -> BLANK high at pc 0-1 and 7-9; Tblank2=20 -> BLANK high over the whole period.
REQ-052 FREQ=1, FREQ_STEP=2, FREQ_RATE=2, N=5 -> FREQ_OUT 1,1,3,3,5; FREQ_UPD twice; FREQ=2^48-1, STEP=1 -> wraps to 0.
REQ-053 TIME_START=5 loaded at SYS_TIME=50 -> ERR_LATE pulse and immediate RUN; N=0 -> DONE with no TX_EN.
REQ-054 SPI_WR mid-RUN -> macro defined: restart with new parameters and no DONE; macro undefined: ERR_BUSY pulse and original timing intact.
REQ-055 rst at pc=4 of impulse 1 -> all outputs 0 next cycle, IDLE; clk_en low for 5 cycles mid-RUN -> TX_EN timing stretched by exactly 5 cycles.
